// File: rtl/sum_job_scheduler.sv
// Round-robin job scheduler and list-walk sequencer for the linked-list summation datapath.
// Optional node-count watchdog: define SJS_WATCHDOG_EN (otherwise err0/err1 are tied 0).
module sum_job_scheduler #(
    parameter int DW        = 32,
    parameter int AW        = 8,
    parameter int MEM_LAT   = 1,
    parameter int MAX_NODES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] base0,
    input  logic [AW-1:0] base1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] result0,
    output logic [DW-1:0] result1,
    output logic          err0,
    output logic          err1,
    output logic          busy,
    output logic          ld_sum,
    output logic          ld_next,
    output logic          sum_sel,
    output logic          next_sel,
    output logic          a_sel,
    output logic [AW-1:0] next_init,
    input  logic          next_zero,
    input  logic [DW-1:0] sum_in
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_A, S_ADD, S_WAIT_N, S_LINK, S_CHECK, S_FINISH
    } state_t;

    localparam bit         NO_WAIT   = (MEM_LAT == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    pend;
    logic [AW-1:0] base0_q, base1_q;
    logic          gnt;
    logic          rr;
    logic [3:0]    wait_cnt;
    logic          wd_hit;

    // A done clears its pending bit, but a request in that same cycle re-arms it.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            base0_q <= '0;
            base1_q <= '0;
        end else begin
            if (done0) pend[0] <= 1'b0;
            if (done1) pend[1] <= 1'b0;
            if (req0 && (!pend[0] || done0)) begin
                pend[0] <= 1'b1;
                base0_q <= base0;
            end
            if (req1 && (!pend[1] || done1)) begin
                pend[1] <= 1'b1;
                base1_q <= base1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt      <= 1'b0;
            rr       <= 1'b0;
            wait_cnt <= '0;
            result0  <= '0;
            result1  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && |pend) begin
                gnt <= (pend == 2'b11) ? rr : pend[1];
                rr  <= ~rr;
            end
            // Reload on every entry into a wait state, then count down to zero.
            if ((state_d == S_WAIT_A || state_d == S_WAIT_N) && state_d != state_q)
                wait_cnt <= WAIT_LOAD;
            else if (wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 1'b1;
            if (done0) result0 <= sum_in;
            if (done1) result1 <= sum_in;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        ld_sum    = 1'b0;
        ld_next   = 1'b0;
        sum_sel   = 1'b0;
        next_sel  = 1'b0;
        a_sel     = 1'b0;
        next_init = '0;
        done0     = 1'b0;
        done1     = 1'b0;
        case (state_q)
            S_IDLE:   if (|pend) state_d = S_INIT;
            S_INIT: begin
                ld_sum    = 1'b1;
                ld_next   = 1'b1;
                next_init = gnt ? base1_q : base0_q;
                state_d   = NO_WAIT ? S_ADD : S_WAIT_A;
            end
            S_WAIT_A: begin
                a_sel = 1'b1;
                if (wait_cnt == 4'd0) state_d = S_ADD;
            end
            S_ADD: begin
                a_sel   = 1'b1;
                sum_sel = 1'b1;
                ld_sum  = 1'b1;
                state_d = NO_WAIT ? S_LINK : S_WAIT_N;
            end
            S_WAIT_N: if (wait_cnt == 4'd0) state_d = S_LINK;
            S_LINK: begin
                next_sel = 1'b1;
                ld_next  = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (next_zero || wd_hit) state_d = S_FINISH;
                else                     state_d = NO_WAIT ? S_ADD : S_WAIT_A;
            end
            S_FINISH: begin
                done0   = !gnt;
                done1   = gnt;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

`ifdef SJS_WATCHDOG_EN
    localparam int CW = $clog2(MAX_NODES + 1);
    logic [CW-1:0] node_cnt;

    assign wd_hit = !next_zero && (node_cnt == CW'(MAX_NODES));

    // err is captured on the way into FINISH so it is valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_cnt <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            if (state_q == S_INIT)     node_cnt <= '0;
            else if (state_q == S_ADD) node_cnt <= node_cnt + 1'b1;
            if (state_q == S_CHECK && state_d == S_FINISH) begin
                if (gnt) err1 <= wd_hit;
                else     err0 <= wd_hit;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err0   = 1'b0;
    assign err1   = 1'b0;
`endif

endmodule

// File: tb/tb_sum_job_scheduler.sv
// Directed bench for sum_job_scheduler with a behavioural list-memory datapath (MEM_LAT=1).
// Covers latency, round-robin order, intake rules, mid-job reset and the self-loop case.
module tb_sum_job_scheduler;
    localparam int DW        = 32;
    localparam int AW        = 8;
    localparam int MEM_LAT   = 1;
    localparam int MAX_NODES = 4;

    logic          clk, rst;
    logic          req0, req1;
    logic [AW-1:0] base0, base1;
    logic          done0, done1, err0, err1, busy;
    logic [DW-1:0] result0, result1;
    logic          ld_sum, ld_next, sum_sel, next_sel, a_sel;
    logic [AW-1:0] next_init;
    logic          next_zero;
    logic [DW-1:0] sum_in;

    sum_job_scheduler #(.DW(DW), .AW(AW), .MEM_LAT(MEM_LAT), .MAX_NODES(MAX_NODES)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .base0(base0), .base1(base1),
        .done0(done0), .done1(done1), .result0(result0), .result1(result1),
        .err0(err0), .err1(err1), .busy(busy),
        .ld_sum(ld_sum), .ld_next(ld_next), .sum_sel(sum_sel), .next_sel(next_sel),
        .a_sel(a_sel), .next_init(next_init), .next_zero(next_zero), .sum_in(sum_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: node at a holds {mem[a]=link, mem[a+1]=value}; read data lags the address one cycle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] next_r, addr, addr_q;
    logic [DW-1:0] sum_r, rd;

    assign addr      = a_sel ? next_r + AW'(1) : next_r;
    assign rd        = mem[addr_q];
    assign next_zero = (next_r == '0);
    assign sum_in    = sum_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_r <= '0;
            sum_r  <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= addr;
            if (ld_sum)  sum_r  <= sum_sel ? sum_r + rd : '0;
            if (ld_next) next_r <= next_sel ? rd[AW-1:0] : next_init;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic post(input bit r0, input bit r1, input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        req0 = r0;
        req1 = r1;
        if (r0) base0 = b0;
        if (r1) base1 = b1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Returns at the negedge where the wanted done is high; busy_cyc counts busy cycles seen on the way.
    task automatic wait_done(input bit r, input int limit, output int busy_cyc, output bit seen, output bit other);
        busy_cyc = 0;
        seen     = 1'b0;
        other    = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (r ? done1 : done0)      seen  = 1'b1;
            else if (r ? done0 : done1) other = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] ctl_vec();
        return DW'({done0, done1, err0, err1, busy, ld_sum, ld_next, sum_sel, next_sel, a_sel, next_init});
    endfunction

    int  cyc;
    bit  seen, other, found;
    int  idle_cnt;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0]  = 32'd2;  mem[1]  = 32'd5;
        mem[2]  = 32'd4;  mem[3]  = 32'd7;
        mem[4]  = 32'd0;  mem[5]  = 32'd9;
        mem[6]  = 32'd0;  mem[7]  = 32'hFFFF_FFFF;
        mem[8]  = 32'd10; mem[9]  = 32'd3;
        mem[10] = 32'd0;  mem[11] = 32'd4;
        mem[12] = 32'd12; mem[13] = 32'd1;
        mem[14] = 32'd0;  mem[15] = 32'd100;
        req0 = 1'b0; req1 = 1'b0; base0 = '0; base1 = '0;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_ctl", ctl_vec(), '0);
        check("rst_res0", result0, '0);
        check("rst_res1", result1, '0);
        rst = 1'b0;
        @(negedge clk);

        // Three-node list on requester 0: INIT + 3*5 + FINISH busy cycles
        post(1'b1, 1'b0, 8'd0, 8'd0);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t1_done", seen, 1);
        check("t1_lat", cyc, 17);
        check("t1_err", err0, 0);
        @(negedge clk);
        check("t1_res", result0, 32'd21);

        // Simultaneous pair after reset: requester 0 wins, then 1
        do_reset();
        post(1'b1, 1'b1, 8'd0, 8'd6);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t2_done0", seen, 1);
        check("t2_order01", other, 0);
        wait_done(1'b1, 100, cyc, seen, other);
        check("t2_done1", seen, 1);
        @(negedge clk);
        check("t2_res1", result1, 32'hFFFF_FFFF);
        check("t2_res0_held", result0, 32'd21);

        // One-node list: 7 busy cycles; this grant leaves the pointer favouring requester 1
        post(1'b1, 1'b0, 8'd6, 8'd0);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t3_done", seen, 1);
        check("t3_lat", cyc, 7);
        @(negedge clk);
        check("t3_res", result0, 32'hFFFF_FFFF);

        // Next simultaneous pair: requester 1 first
        post(1'b1, 1'b1, 8'd0, 8'd8);
        wait_done(1'b1, 100, cyc, seen, other);
        check("t2b_done1", seen, 1);
        check("t2b_order10", other, 0);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t2b_done0", seen, 1);
        @(negedge clk);
        check("t2b_res1", result1, 32'd7);
        check("t2b_res0", result0, 32'd21);

        // Reset during ADD of job 0
        post(1'b1, 1'b0, 8'd0, 8'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (a_sel && sum_sel && ld_sum) found = 1'b1;
            else @(negedge clk);
        end
        check("t4_add_seen", found, 1);
        rst = 1'b1;
        #1;
        check("t4_rst_ctl", ctl_vec(), '0);
        check("t4_rst_res0", result0, '0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(1'b0, 30, cyc, seen, other);
        check("t4_no_done", seen, 0);
        check("t4_idle", busy, 0);
        post(1'b1, 1'b0, 8'd8, 8'd0);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t4_repost", seen, 1);
        @(negedge clk);
        check("t4_res", result0, 32'd7);

        // Re-pulse while pending is ignored; request in the done cycle starts a second job
        post(1'b1, 1'b0, 8'd0, 8'd0);
        post(1'b1, 1'b0, 8'd14, 8'd0);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t6_done", seen, 1);
        post(1'b1, 1'b0, 8'd8, 8'd0);
        check("t6_res_first", result0, 32'd21);
        wait_done(1'b0, 100, cyc, seen, other);
        check("t6_second", seen, 1);
        @(negedge clk);
        check("t6_res_second", result0, 32'd7);

        // Self-looping list
        post(1'b0, 1'b1, 8'd0, 8'd12);
`ifdef SJS_WATCHDOG_EN
        wait_done(1'b1, 200, cyc, seen, other);
        check("t5_wd_done", seen, 1);
        check("t5_wd_lat", cyc, 22);
        check("t5_wd_err", err1, 1);
        @(negedge clk);
        check("t5_wd_res", result1, 32'd4);
`else
        idle_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy || done1) idle_cnt++;
        end
        check("t5_loop_busy", idle_cnt, 0);
        check("t5_err", err1, 0);
        do_reset();
        check("t5_rst_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
